note_scheduler: RTL

Sequencing controller that sits between the song reader and a bank of `NUM_VOICES` note_player voices. It accepts note commands one at a time and allocates each one to the lowest-numbered free voice, pulsing that voice's load strobe. It implements chords (notes that do not advance time) and rests, and holds the song reader off for a note's full duration, counted in beats, when the note advances time.

---
 rtl/note_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: accepts note commands from the song reader, allocates each
// sounding note to the lowest-numbered free voice, and holds the reader off
// for the note's duration in beats when the note advances time.
module note_scheduler #(
  parameter int unsigned NUM_VOICES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_enable,
  input  logic                      beat,
  input  logic                      note_valid,
  input  logic [5:0]                note,
  input  logic [5:0]                duration,
  input  logic                      advance,
  output logic                      note_ready,
  input  logic [NUM_VOICES-1:0]     voice_done,
  output logic [NUM_VOICES-1:0]     voice_load,
  output logic [6*NUM_VOICES-1:0]   voice_note,
  output logic [6*NUM_VOICES-1:0]   voice_duration,
  output logic                      all_idle
);

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    WAIT
  } state_t;

  state_t state, state_next;

  logic [5:0]            hold_note;
  logic [5:0]            hold_dur;
  logic                  hold_adv;
  logic [5:0]            count;
  logic [NUM_VOICES-1:0] busy;
  logic [NUM_VOICES-1:0] done_prev;
  logic [NUM_VOICES-1:0] free;
  logic [NUM_VOICES-1:0] grant;
  logic [NUM_VOICES-1:0] done_rise;
  logic                  xfer;
  logic                  alloc_fire;
  logic                  count_en;
  logic                  rest_wait;

  // Voice availability: lowest free voice as a one-hot grant, and done edges.
  always_comb begin
    free      = ~busy;
    grant     = free & (~free + NUM_VOICES'(1));
    done_rise = voice_done & ~done_prev;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (xfer && duration != 6'd0) begin
          if (note != 6'd0)  state_next = ALLOC;
          else if (advance)  state_next = WAIT;
        end
      end
      ALLOC: begin
        if (alloc_fire) state_next = hold_adv ? WAIT : IDLE;
      end
      WAIT: begin
        if (count_en && count == 6'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and control strobes derived from the current state.
  always_comb begin
    note_ready = (state == IDLE);
    xfer       = note_valid && note_ready;
    rest_wait  = xfer && (note == 6'd0) && (duration != 6'd0) && advance;
    alloc_fire = (state == ALLOC) && (|free);
    count_en   = (state == WAIT) && beat && play_enable;
    all_idle   = (state == IDLE) && (busy == '0);
  end

  // Command holding registers and beat counter; the counter is only ever
  // loaded with a non-zero duration, so the decrement cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_note <= '0;
      hold_dur  <= '0;
      hold_adv  <= 1'b0;
      count     <= '0;
    end else begin
      if (xfer) begin
        hold_note <= note;
        hold_dur  <= duration;
        hold_adv  <= advance;
      end
      if (rest_wait)                  count <= duration;
      else if (alloc_fire && hold_adv) count <= hold_dur;
      else if (count_en)               count <= count - 6'd1;
    end
  end

  // Busy tracking: a load sets busy, a rising done clears it, set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      done_prev <= '1;
    end else begin
      busy      <= (busy & ~done_rise) | (alloc_fire ? grant : '0);
      done_prev <= voice_done;
    end
  end

  // Per-voice load strobe and sticky note/duration slices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voice_load     <= '0;
      voice_note     <= '0;
      voice_duration <= '0;
    end else begin
      voice_load <= alloc_fire ? grant : '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (alloc_fire && grant[i]) begin
          voice_note[6*i +: 6]     <= hold_note;
          voice_duration[6*i +: 6] <= hold_dur;
        end
      end
    end
  end

endmodule
